// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder running one data-bus request/response transaction per start pulse
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        memu_valid,
    input  logic        DMre,
    input  logic        DMwe,
    input  logic [2:0]  dreq_info,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        memu_finish,
    output logic [63:0] rdata,
    output logic        misalign,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]  info_q, info_d;
    logic        ld_q, ld_d, st_q, st_d, mis_q, mis_d;
    logic [2:0]  amask, off;
    logic        access, mis_in, sx;
    logic [63:0] raw, load_ext;
    logic [7:0]  lanes;
    assign access = DMre | DMwe;
    assign amask = dreq_info[1:0] == 2'd0 ? 3'd0 : dreq_info[1:0] == 2'd1 ? 3'd1 : dreq_info[1:0] == 2'd2 ? 3'd3 : 3'd7;
    assign mis_in = |(addr[2:0] & amask);
    assign off = addr_q[2:0];
    assign raw = dresp_data >> {off, 3'b000};
    assign sx = ~info_q[2] & (info_q[1:0] == 2'd0 ? raw[7] : info_q[1:0] == 2'd1 ? raw[15] : raw[31]);
    assign load_ext = info_q[1:0] == 2'd0 ? {{56{sx}}, raw[7:0]} :
                      info_q[1:0] == 2'd1 ? {{48{sx}}, raw[15:0]} :
                      info_q[1:0] == 2'd2 ? {{32{sx}}, raw[31:0]} : raw;
    assign lanes = info_q[1:0] == 2'd0 ? 8'h01 : info_q[1:0] == 2'd1 ? 8'h03 : info_q[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    assign memu_finish = state_q == DONE;
    assign misalign = (state_q == DONE) & mis_q;
    assign dreq_valid = state_q == REQ;
    assign dreq_addr = addr_q;
    assign dreq_size = {1'b0, info_q[1:0]};
    assign dreq_strobe = st_q ? lanes << off : 8'h00;
    assign dreq_data = wdata_q << {off, 3'b000};
    assign rdata = rdata_q;
    // next state: capture on start in IDLE, track the bus handshake, latch extended load data on data_ok
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        info_d = info_q;
        ld_d = ld_q;
        st_d = st_q;
        mis_d = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (memu_valid) begin
                addr_d = addr;
                wdata_d = wdata;
                info_d = dreq_info;
                ld_d = DMre & ~DMwe;
                st_d = DMwe;
                mis_d = access & mis_in;
                state_d = access && !mis_in ? REQ : DONE;
            end
            REQ: if (dresp_addr_ok) begin
                state_d = dresp_data_ok ? DONE : WAIT;
                rdata_d = dresp_data_ok && ld_q ? load_ext : rdata_q;
            end
            WAIT: if (dresp_data_ok) begin
                state_d = DONE;
                rdata_d = ld_q ? load_ext : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and captured-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            info_q <= '0;
            ld_q <= 1'b0;
            st_q <= 1'b0;
            mis_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            info_q <= info_d;
            ld_q <= ld_d;
            st_q <= st_d;
            mis_q <= mis_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst, memu_valid, DMre, DMwe;
    logic [2:0]  dreq_info;
    logic [63:0] addr, wdata;
    logic        memu_finish, misalign, dreq_valid;
    logic [63:0] rdata, dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    int n_chk = 0;
    int n_fail = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .memu_valid(memu_valid), .DMre(DMre), .DMwe(DMwe),
        .dreq_info(dreq_info), .addr(addr), .wdata(wdata), .memu_finish(memu_finish),
        .rdata(rdata), .misalign(misalign), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic clr;
        memu_valid = 0; DMre = 0; DMwe = 0; dresp_addr_ok = 0; dresp_data_ok = 0;
    endtask

    task automatic start(input logic re, input logic we, input logic [2:0] info, input logic [63:0] a, input logic [63:0] w);
        memu_valid = 1; DMre = re; DMwe = we; dreq_info = info; addr = a; wdata = w;
    endtask

    task automatic resp(input logic a, input logic d, input logic [63:0] data);
        dresp_addr_ok = a; dresp_data_ok = d; dresp_data = data;
    endtask

    task automatic fast(input string tag, input logic re, input logic we, input logic [2:0] info,
                        input logic [63:0] a, input logic [63:0] w, input logic [63:0] rd,
                        input logic [7:0] strb, input logic [63:0] dd, input logic [63:0] exp_rdata);
        start(re, we, info, a, w);
        smp; chk({tag, " c0 valid"}, dreq_valid, 0); chk({tag, " c0 finish"}, memu_finish, 0);
        nxt; clr; resp(1, 1, rd);
        smp;
        chk({tag, " c1 valid"}, dreq_valid, 1);
        chk({tag, " c1 addr"}, dreq_addr, a);
        chk({tag, " c1 size"}, dreq_size, {1'b0, info[1:0]});
        chk({tag, " c1 strobe"}, dreq_strobe, strb);
        chk({tag, " c1 data"}, dreq_data, dd);
        chk({tag, " c1 finish"}, memu_finish, 0);
        nxt; clr;
        smp;
        chk({tag, " c2 finish"}, memu_finish, 1);
        chk({tag, " c2 misalign"}, misalign, 0);
        chk({tag, " c2 valid"}, dreq_valid, 0);
        chk({tag, " c2 rdata"}, rdata, exp_rdata);
        nxt;
        smp; chk({tag, " c3 finish"}, memu_finish, 0);
        nxt; nxt; nxt;
    endtask

    initial begin
        rst = 1; clr; dreq_info = 0; addr = 0; wdata = 0; dresp_data = 0;
        nxt; nxt; nxt;
        smp;
        chk("rst finish", memu_finish, 0);
        chk("rst misalign", misalign, 0);
        chk("rst rdata", rdata, 0);
        chk("rst valid", dreq_valid, 0);
        chk("rst strobe", dreq_strobe, 0);
        chk("rst addr", dreq_addr, 0);
        chk("rst data", dreq_data, 0);
        chk("rst size", dreq_size, 0);
        nxt; rst = 0; nxt;

        fast("ld", 1, 0, 3'b011, 64'h80001008, 64'h0, 64'h1122334455667788, 8'h00, 64'h0, 64'h1122334455667788);
        fast("lb", 1, 0, 3'b000, 64'h80000003, 64'h0, 64'h0000000080000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80);
        fast("lbu", 1, 0, 3'b100, 64'h80000003, 64'h0, 64'h0000000080000000, 8'h00, 64'h0, 64'h80);
        fast("sw", 0, 1, 3'b010, 64'h80000004, 64'hDEADBEEF, 64'h5555555555555555, 8'hF0, 64'hDEADBEEF00000000, 64'h80);
        fast("lh6", 1, 0, 3'b001, 64'h80000006, 64'h0, 64'h8001000000000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001);
        fast("rw", 1, 1, 3'b000, 64'h80000005, 64'hAB, 64'h0, 8'h20, 64'h0000AB0000000000, 64'hFFFFFFFFFFFF8001);

        start(1, 0, 3'b001, 64'h80000001, 64'h0);
        smp; chk("mis c0 valid", dreq_valid, 0);
        nxt; clr;
        smp;
        chk("mis c1 valid", dreq_valid, 0);
        chk("mis c1 finish", memu_finish, 1);
        chk("mis c1 misalign", misalign, 1);
        chk("mis c1 rdata", rdata, 64'hFFFFFFFFFFFF8001);
        nxt;
        smp; chk("mis c2 finish", memu_finish, 0); chk("mis c2 misalign", misalign, 0); chk("mis c2 valid", dreq_valid, 0);
        nxt; nxt; nxt;

        start(0, 0, 3'b011, 64'h80000001, 64'h0);
        nxt; clr;
        smp;
        chk("none c1 finish", memu_finish, 1);
        chk("none c1 misalign", misalign, 0);
        chk("none c1 valid", dreq_valid, 0);
        nxt;
        smp; chk("none c2 finish", memu_finish, 0);
        nxt; nxt; nxt;

        start(1, 0, 3'b011, 64'h80000010, 64'h0);
        nxt; clr;
        for (int i = 1; i <= 3; i++) begin
            smp;
            chk($sformatf("stall c%0d valid", i), dreq_valid, 1);
            chk($sformatf("stall c%0d addr", i), dreq_addr, 64'h80000010);
            chk($sformatf("stall c%0d size", i), dreq_size, 3'b011);
            chk($sformatf("stall c%0d strobe", i), dreq_strobe, 0);
            nxt;
        end
        resp(1, 0, 64'h0);
        smp; chk("stall c4 valid", dreq_valid, 1); chk("stall c4 finish", memu_finish, 0);
        nxt; clr; start(0, 1, 3'b000, 64'h0, 64'hFF);
        smp; chk("stall c5 valid", dreq_valid, 0); chk("stall c5 finish", memu_finish, 0);
        nxt; clr;
        smp; chk("stall c6 valid", dreq_valid, 0); chk("stall c6 finish", memu_finish, 0);
        nxt; resp(0, 1, 64'hCAFEF00D12345678);
        smp; chk("stall c7 finish", memu_finish, 0);
        nxt; clr;
        smp; chk("stall c8 finish", memu_finish, 1); chk("stall c8 rdata", rdata, 64'hCAFEF00D12345678);
        nxt;
        smp; chk("stall c9 finish", memu_finish, 0); chk("stall c9 valid", dreq_valid, 0); chk("stall c9 strobe", dreq_strobe, 0);
        nxt; nxt; nxt;

        start(1, 0, 3'b011, 64'h80000020, 64'h0);
        nxt; clr; resp(1, 0, 64'h0);
        smp; chk("rstw c1 valid", dreq_valid, 1);
        nxt; clr;
        smp; chk("rstw c2 valid", dreq_valid, 0);
        nxt; rst = 1;
        smp;
        nxt; rst = 0;
        smp;
        chk("rstw c4 finish", memu_finish, 0);
        chk("rstw c4 valid", dreq_valid, 0);
        chk("rstw c4 rdata", rdata, 0);
        chk("rstw c4 addr", dreq_addr, 0);
        chk("rstw c4 size", dreq_size, 0);
        chk("rstw c4 misalign", misalign, 0);
        nxt; resp(0, 1, 64'hFFFFFFFFFFFFFFFF);
        smp; chk("rstw c5 finish", memu_finish, 0);
        nxt; clr;
        smp; chk("rstw c6 finish", memu_finish, 0); chk("rstw c6 rdata", rdata, 0);
        nxt;
        smp; chk("rstw c7 finish", memu_finish, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
